// File: rtl/inst_fetch_bridge_pkg.sv
// Purpose : shared FSM state encodings, filler instruction and pair layout for the fetch bridge.
// Latency : n/a (types and constants only).
// Backpres: n/a.
package inst_fetch_bridge_pkg;

    // addi x0,x0,0 -- used for reset contents and for the dead slot of a half fill
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IFB_ST_IDLE   = 3'd0,
        IFB_ST_REQ_HI = 3'd1,
        IFB_ST_RSP_HI = 3'd2,
        IFB_ST_REQ_LO = 3'd3,
        IFB_ST_RSP_LO = 3'd4
    } ifb_state_e;

    // hi = word at the 8-byte aligned address, lo = word at +4
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } inst_pair_t;

endpackage

// File: rtl/ifb_pair_buf.sv
// Purpose : one-entry instruction-pair buffer with tag compare for the fetch bridge.
// Latency : hit is combinational from look_tag/look_odd; a fill is visible the cycle after fill_vld.
// Backpres: none; a fill is accepted unconditionally and replaces the whole entry at once.
//
// Ports: clk/rst_n; fill_vld/fill_tag/fill_full/fill_dat write the entry atomically;
//        look_tag/look_odd are the current fetch tag and address bit 2; hit/pair_dat read back.
module ifb_pair_buf
    import inst_fetch_bridge_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_vld,
    input  logic [ADDR_W-4:0] fill_tag,
    input  logic              fill_full,
    input  inst_pair_t        fill_dat,
    input  logic [ADDR_W-4:0] look_tag,
    input  logic              look_odd,
    output logic              hit,
    output inst_pair_t        pair_dat
);

    logic              vld_q;
    logic              full_q;
    logic [ADDR_W-4:0] tag_q;
    inst_pair_t        dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            full_q <= 1'b0;
            tag_q  <= '0;
            dat_q  <= '{hi: NOP_INST, lo: NOP_INST};
        end else if (fill_vld) begin
            vld_q  <= 1'b1;
            full_q <= fill_full;
            tag_q  <= fill_tag;
            dat_q  <= fill_dat;
        end
    end

    // A half entry (full_q=0) only serves fetches whose first slot is dead.
    assign hit      = vld_q & (tag_q == look_tag) & (full_q | look_odd);
    assign pair_dat = dat_q;

endmodule

// File: rtl/inst_fetch_bridge.sv
// Purpose : memory-side responder building 64-bit instruction pairs from two 32-bit reads.
// Latency : hit -> stall=0 same cycle; miss -> stall=0 five cycles later (gnt same cycle, rvalid +1).
// Backpres: mem_req/mem_addr held until mem_gnt; fetch stage is held with stall until the pair is valid.
//
// Ports: clk, rst_n (async, active-low); fetch_addr in, inst_pair/stall out to the fetch stage;
//        mem_req/mem_addr out, mem_gnt/mem_rvalid/mem_rdata in on the memory side.
// Build option: IFB_HALF_SKIP_EN -- a miss with fetch_addr[2]=1 reads only the second word.
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = INST_NOP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [63:0]       inst_pair,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int TAG_W = ADDR_W - 3;

    ifb_state_e       state_q, state_d;
    logic [TAG_W-1:0] req_tag_q;
    logic [TAG_W-1:0] cur_tag;
    logic [31:0]      hi_tmp_q;
    logic             hit;
    logic             tag_match;
    logic             start_miss;
    logic             hi_we;
    logic             fill_vld;
    logic             fill_full;
    inst_pair_t       fill_dat;
    inst_pair_t       buf_dat;
    logic             unused_addr_lsb;

    assign cur_tag         = fetch_addr[ADDR_W-1:3];
    assign tag_match       = (req_tag_q == cur_tag);
    assign unused_addr_lsb = ^fetch_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IFB_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outstanding requests/responses always run to completion; a redirect is only
    // acted on when the response arrives, by comparing against the live fetch tag.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_addr   = '0;
        start_miss = 1'b0;
        hi_we      = 1'b0;
        fill_vld   = 1'b0;
        case (state_q)
            IFB_ST_IDLE: begin
                if (!hit) begin
                    start_miss = 1'b1;
`ifdef IFB_HALF_SKIP_EN
                    state_d = fetch_addr[2] ? IFB_ST_REQ_LO : IFB_ST_REQ_HI;
`else
                    state_d = IFB_ST_REQ_HI;
`endif
                end
            end
            IFB_ST_REQ_HI: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag_q, 3'b000};
                if (mem_gnt) state_d = IFB_ST_RSP_HI;
            end
            IFB_ST_RSP_HI: begin
                if (mem_rvalid) begin
                    hi_we   = tag_match;
                    state_d = tag_match ? IFB_ST_REQ_LO : IFB_ST_IDLE;
                end
            end
            IFB_ST_REQ_LO: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag_q, 3'b100};
                if (mem_gnt) state_d = IFB_ST_RSP_LO;
            end
            IFB_ST_RSP_LO: begin
                if (mem_rvalid) begin
                    fill_vld = tag_match;
                    state_d  = IFB_ST_IDLE;
                end
            end
            default: state_d = IFB_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_tag_q <= '0;
            hi_tmp_q  <= '0;
        end else begin
            if (start_miss) req_tag_q <= cur_tag;
            if (hi_we)      hi_tmp_q  <= mem_rdata;
        end
    end

`ifdef IFB_HALF_SKIP_EN
    // Remembers that the current fetch skipped the first word.
    logic req_half_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_half_q <= 1'b0;
        end else if (start_miss) begin
            req_half_q <= fetch_addr[2];
        end
    end

    assign fill_full = ~req_half_q;
    assign fill_dat  = req_half_q ? '{hi: NOP_INST, lo: mem_rdata}
                                  : '{hi: hi_tmp_q, lo: mem_rdata};
`else
    assign fill_full = 1'b1;
    assign fill_dat  = '{hi: hi_tmp_q, lo: mem_rdata};
`endif

    ifb_pair_buf #(
        .ADDR_W   (ADDR_W),
        .NOP_INST (NOP_INST)
    ) u_pair_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill_vld  (fill_vld),
        .fill_tag  (req_tag_q),
        .fill_full (fill_full),
        .fill_dat  (fill_dat),
        .look_tag  (cur_tag),
        .look_odd  (fetch_addr[2]),
        .hit       (hit),
        .pair_dat  (buf_dat)
    );

    assign stall     = ~hit;
    assign inst_pair = buf_dat;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Purpose : self-checking bench for inst_fetch_bridge with a transaction-level pair model.
// Latency : checks exact miss-to-valid cycle counts on directed scenarios.
// Backpres: memory model can withhold gnt and delay rvalid randomly.
module tb_inst_fetch_bridge;

    localparam logic [63:0] NOP_PAIR = 64'h0000_0013_0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_addr;
    logic [63:0] inst_pair;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    inst_fetch_bridge #(.ADDR_W(32), .NOP_INST(32'h0000_0013)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_addr (fetch_addr),
        .inst_pair  (inst_pair),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model of the buffer contents
    bit          m_vld;
    logic [28:0] m_tag;
    bit          m_full;
    logic [63:0] m_pair;
    bit          pend_fill;
    logic [28:0] pend_tag;
    bit          pend_full;
    logic [63:0] pend_pair;
    bit          lk_vld;
    logic [31:0] lk_addr;

    // memory model
    rsp_t        rq[$];
    logic [31:0] grants[$];
    int          gnt_hold;
    bit          gnt_rand;
    int          dmax;
    bit          prev_req;
    bit          prev_gnt;
    logic [31:0] prev_addr;
    bit          obs_stall;
    int          req_cycles;
    logic [31:0] req_addrs[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_word = 32'hAAAA_0001;
            32'h0000_0104: mem_word = 32'hBBBB_0002;
            default:       mem_word = {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
        endcase
    endfunction

    function automatic logic [63:0] pair_of(input logic [31:0] a);
        logic [31:0] base;
        base = {a[31:3], 3'b000};
        pair_of = {mem_word(base), mem_word(base + 32'd4)};
    endfunction

    task automatic apply_reset();
        rst_n      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        rq.delete();
        m_vld      = 1'b0;
        m_tag      = '0;
        m_full     = 1'b0;
        m_pair     = NOP_PAIR;
        pend_fill  = 1'b0;
        lk_vld     = 1'b0;
        prev_req   = 1'b0;
        prev_gnt   = 1'b0;
        gnt_hold   = 0;
        gnt_rand   = 1'b0;
        dmax       = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle, entered and left at a negedge. Drives fetch_addr and the
    // memory response, then checks stall/inst_pair against the model.
    task automatic cycle(input logic [31:0] a);
        logic [31:0] ra;
        bit          kept;
        bit          exp_stall;
        int          due;
        if (pend_fill) begin
            m_vld     = 1'b1;
            m_tag     = pend_tag;
            m_full    = pend_full;
            m_pair    = pend_pair;
            pend_fill = 1'b0;
        end
        fetch_addr = a;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            ra = rq[0].addr;
            void'(rq.pop_front());
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(ra);
            kept       = (ra[31:3] == a[31:3]);
            if (kept && ra[2]) begin
                pend_fill = 1'b1;
                pend_tag  = ra[31:3];
                pend_full = lk_vld && (lk_addr == ra - 32'd4);
                pend_pair = pend_full ? pair_of(ra) : {32'h0000_0013, mem_word(ra)};
            end
            lk_vld  = kept;
            lk_addr = ra;
        end
        #1;
        exp_stall = !(m_vld && m_tag == a[31:3] && (m_full || a[2]));
        n_cmp++;
        if (stall !== exp_stall) begin
            n_err++;
            $display("FAIL stall cyc=%0d addr=%h got=%b exp=%b", cyc, a, stall, exp_stall);
        end
        n_cmp++;
        if (inst_pair !== m_pair) begin
            n_err++;
            $display("FAIL inst_pair cyc=%0d addr=%h got=%h exp=%h", cyc, a, inst_pair, m_pair);
        end
        if (prev_req && !prev_gnt) begin
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
                n_err++;
                $display("FAIL req_hold cyc=%0d got req=%b addr=%h exp req=1 addr=%h",
                         cyc, mem_req, mem_addr, prev_addr);
            end
        end
        if (mem_req === 1'b1) begin
            req_cycles++;
            req_addrs.push_back(mem_addr);
            n_cmp++;
            if (mem_addr[1:0] !== 2'b00) begin
                n_err++;
                $display("FAIL mem_addr_align cyc=%0d got=%h exp=word aligned", cyc, mem_addr);
            end
        end
        obs_stall = stall;
        if (mem_req && gnt_hold > 0) begin
            mem_gnt = 1'b0;
            gnt_hold--;
        end else begin
            mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (mem_req && mem_gnt) begin
            grants.push_back(mem_addr);
            due = cyc + ((dmax > 1) ? int'($urandom_range(1, dmax)) : 1);
            if (rq.size() > 0 && due <= rq[$].due) due = rq[$].due + 1;
            rq.push_back('{addr: mem_addr, due: due});
        end
        prev_req  = mem_req;
        prev_gnt  = mem_gnt;
        prev_addr = mem_addr;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        fetch_addr = 32'h0000_0100;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++; $display("FAIL reset_stall got=%b exp=1", stall);
        end
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++; $display("FAIL reset_mem_req got=%b exp=0", mem_req);
        end
        n_cmp++;
        if (mem_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr);
        end
        n_cmp++;
        if (inst_pair !== NOP_PAIR) begin
            n_err++; $display("FAIL reset_inst_pair got=%h exp=%h", inst_pair, NOP_PAIR);
        end
        apply_reset();
    endtask

    task automatic test_cold_miss();
        int first0;
        apply_reset();
        grants.delete();
        first0 = -1;
        for (int k = 0; k < 12; k++) begin
            cycle(32'h0000_0100);
            if (first0 < 0 && !obs_stall) first0 = k;
        end
        n_cmp++;
        if (first0 != 5) begin
            n_err++; $display("FAIL cold_latency got=%0d exp=5", first0);
        end
        n_cmp++;
        if (grants.size() != 2 || grants[0] !== 32'h100 || grants[1] !== 32'h104) begin
            n_err++; $display("FAIL cold_reads got=%p exp=100,104", grants);
        end
        n_cmp++;
        if (inst_pair !== 64'hAAAA_0001_BBBB_0002) begin
            n_err++; $display("FAIL cold_pair got=%h exp=aaaa0001bbbb0002", inst_pair);
        end
    endtask

    task automatic test_hit();
        int r0;
        grants.delete();
        r0 = req_cycles;
        cycle(32'h0000_0100);
        n_cmp++;
        if (obs_stall !== 1'b0) begin
            n_err++; $display("FAIL hit_even got=%b exp=0", obs_stall);
        end
        cycle(32'h0000_0104);
        n_cmp++;
        if (obs_stall !== 1'b0) begin
            n_err++; $display("FAIL hit_odd got=%b exp=0", obs_stall);
        end
        n_cmp++;
        if (req_cycles != r0 || grants.size() != 0) begin
            n_err++; $display("FAIL hit_no_req got=%0d req cycles exp=0", req_cycles - r0);
        end
    endtask

    task automatic test_backpressure();
        int first0;
        apply_reset();
        grants.delete();
        req_addrs.delete();
        gnt_hold = 3;
        first0   = -1;
        for (int k = 0; k < 14; k++) begin
            cycle(32'h0000_0100);
            if (first0 < 0 && !obs_stall) first0 = k;
        end
        n_cmp++;
        if (first0 != 8) begin
            n_err++; $display("FAIL bp_latency got=%0d exp=8", first0);
        end
        n_cmp++;
        if (req_addrs.size() != 5 || req_addrs[0] !== 32'h100 || req_addrs[3] !== 32'h100
            || req_addrs[4] !== 32'h104) begin
            n_err++; $display("FAIL bp_addr_hold got=%p exp=100,100,100,100,104", req_addrs);
        end
        n_cmp++;
        if (inst_pair !== 64'hAAAA_0001_BBBB_0002) begin
            n_err++; $display("FAIL bp_pair got=%h exp=aaaa0001bbbb0002", inst_pair);
        end
    endtask

    task automatic test_redirect_hi();
        apply_reset();
        grants.delete();
        cycle(32'h0000_0100);
        cycle(32'h0000_0100);
        cycle(32'h0000_0200);
        n_cmp++;
        if (inst_pair !== NOP_PAIR) begin
            n_err++; $display("FAIL redir_hi_unchanged got=%h exp=%h", inst_pair, NOP_PAIR);
        end
        for (int k = 0; k < 10; k++) cycle(32'h0000_0200);
        n_cmp++;
        if (grants.size() != 3 || grants[0] !== 32'h100 || grants[1] !== 32'h200
            || grants[2] !== 32'h204) begin
            n_err++; $display("FAIL redir_hi_reads got=%p exp=100,200,204", grants);
        end
        n_cmp++;
        if (inst_pair !== pair_of(32'h200) || obs_stall !== 1'b0) begin
            n_err++; $display("FAIL redir_hi_pair got=%h stall=%b exp=%h stall=0",
                              inst_pair, obs_stall, pair_of(32'h200));
        end
    endtask

    task automatic test_redirect_lo();
        apply_reset();
        grants.delete();
        for (int k = 0; k < 4; k++) cycle(32'h0000_0100);
        cycle(32'h0000_0300);
        cycle(32'h0000_0300);
        n_cmp++;
        if (inst_pair !== NOP_PAIR) begin
            n_err++; $display("FAIL redir_lo_no_fill got=%h exp=%h", inst_pair, NOP_PAIR);
        end
        for (int k = 0; k < 10; k++) cycle(32'h0000_0300);
        n_cmp++;
        if (inst_pair !== pair_of(32'h300) || obs_stall !== 1'b0) begin
            n_err++; $display("FAIL redir_lo_pair got=%h stall=%b exp=%h stall=0",
                              inst_pair, obs_stall, pair_of(32'h300));
        end
    endtask

    task automatic test_reset_mid_fetch();
        for (int k = 0; k < 3; k++) cycle(32'h0000_0400);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b1 || mem_req !== 1'b0 || inst_pair !== NOP_PAIR) begin
            n_err++; $display("FAIL reset_mid got stall=%b req=%b pair=%h exp stall=1 req=0 pair=%h",
                              stall, mem_req, inst_pair, NOP_PAIR);
        end
        @(negedge clk);
        apply_reset();
        for (int k = 0; k < 10; k++) cycle(32'h0000_0400);
        n_cmp++;
        if (inst_pair !== pair_of(32'h400)) begin
            n_err++; $display("FAIL reset_mid_refetch got=%h exp=%h", inst_pair, pair_of(32'h400));
        end
    endtask

`ifdef IFB_HALF_SKIP_EN
    task automatic test_half_skip();
        int first0;
        apply_reset();
        grants.delete();
        first0 = -1;
        for (int k = 0; k < 8; k++) begin
            cycle(32'h0000_010C);
            if (first0 < 0 && !obs_stall) first0 = k;
        end
        n_cmp++;
        if (first0 != 3 || grants.size() != 1 || grants[0] !== 32'h10C) begin
            n_err++; $display("FAIL half_fetch got lat=%0d reads=%p exp lat=3 reads=10c", first0, grants);
        end
        n_cmp++;
        if (inst_pair !== {32'h0000_0013, mem_word(32'h10C)}) begin
            n_err++; $display("FAIL half_pair got=%h exp=%h", inst_pair, {32'h0000_0013, mem_word(32'h10C)});
        end
        grants.delete();
        first0 = -1;
        for (int k = 0; k < 10; k++) begin
            cycle(32'h0000_0108);
            if (first0 < 0 && !obs_stall) first0 = k;
        end
        n_cmp++;
        if (first0 != 5 || grants.size() != 2 || grants[0] !== 32'h108 || grants[1] !== 32'h10C) begin
            n_err++; $display("FAIL half_refetch got lat=%0d reads=%p exp lat=5 reads=108,10c", first0, grants);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] pool[4];
        logic [31:0] a;
        int          run;
        int          max_run;
        pool[0] = 32'h0000_0100;
        pool[1] = 32'h0000_0108;
        pool[2] = 32'h0000_2000;
        pool[3] = 32'hFFFF_FFF8;
        apply_reset();
        gnt_rand = 1'b1;
        dmax     = 3;
        a        = pool[0];
        run      = 0;
        max_run  = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!obs_stall || $urandom_range(0, 15) == 0) begin
                a = pool[$urandom_range(0, 3)] | {29'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            end
            cycle(a);
            run = obs_stall ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        n_cmp++;
        if (max_run > 200) begin
            n_err++; $display("FAIL random_progress got=%0d stalled cycles exp<=200", max_run);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        fetch_addr = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        req_cycles = 0;
        obs_stall  = 1'b1;
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_hit();
        test_backpressure();
        test_redirect_hi();
        test_redirect_lo();
        test_reset_mid_fetch();
`ifdef IFB_HALF_SKIP_EN
        test_half_skip();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
